// File: rtl/program_counter_if.sv
// Program-counter bus: next-PC load request from fetch logic and the registered PC results.
interface program_counter_if #(
  parameter int XLEN = 32
);
  logic            en;
  logic [XLEN-1:0] PC_in;
  logic [XLEN-1:0] PC_out;
  logic [XLEN-1:0] PC_plus4;
  logic            misalign_err;

  modport master (
    output en, PC_in,
    input  PC_out, PC_plus4, misalign_err
  );

  modport slave (
    input  en, PC_in,
    output PC_out, PC_plus4, misalign_err
  );
endinterface

// File: rtl/program_counter.sv
// RISC-V program counter: registered PC with load enable and combinational PC+4.
// Optional PC_ALIGN_CHECK_EN: force loaded PCs word-aligned and raise a sticky misalign_err.
module program_counter #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  program_counter_if.slave  pc_bus
);

  localparam logic [XLEN-1:0] RV = XLEN'(RESET_VECTOR);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;

`ifdef PC_ALIGN_CHECK_EN
  logic r_misalign;
  logic w_misaligned;

  assign w_misaligned = |pc_bus.PC_in[1:0];
  assign w_next_pc    = {pc_bus.PC_in[XLEN-1:2], 2'b00};

  // Sticky until reset; stalled cycles never touch it.
  always_ff @(posedge clk) begin
    if (!reset)
      r_misalign <= 1'b0;
    else if (pc_bus.en && w_misaligned)
      r_misalign <= 1'b1;
  end

  assign pc_bus.misalign_err = r_misalign;
`else
  assign w_next_pc           = pc_bus.PC_in;
  assign pc_bus.misalign_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset)
      r_pc <= RV;
    else if (pc_bus.en)
      r_pc <= w_next_pc;
  end

  assign pc_bus.PC_out   = r_pc;
  assign pc_bus.PC_plus4 = r_pc + XLEN'(4);

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: driver pushes model expectations, negedge monitor pops and checks.
module tb_program_counter;

  localparam logic [31:0] RV = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus4;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  program_counter_if #(.XLEN(32)) bus ();

  program_counter #(.XLEN(32), .RESET_VECTOR(RV)) dut (
    .clk    (clk),
    .reset  (reset),
    .pc_bus (bus.slave)
  );

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;
  logic        m_err;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what the PC should hold after an edge with these inputs.
  task automatic step(input logic r, input logic e, input logic [31:0] p);
    exp_t x;
    reset  = r;
    bus.en = e;
    bus.PC_in = p;
    @(posedge clk);
    if (!r) begin
      m_pc  = RV;
      m_err = 1'b0;
    end else if (e) begin
`ifdef PC_ALIGN_CHECK_EN
      m_pc = (p / 4) * 4;
      if (p % 4 != 0) m_err = 1'b1;
`else
      m_pc = p;
`endif
    end
    x.pc    = m_pc;
    x.plus4 = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    x.err   = m_err;
    sb_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: every post-edge output is a response to check.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      chk("PC_out",       bus.PC_out,            x.pc);
      chk("PC_plus4",     bus.PC_plus4,          x.plus4);
      chk("misalign_err", 32'(bus.misalign_err), 32'(x.err));
    end
  end

  initial begin
    logic [31:0] p;
    reset = 1'b1; bus.en = 1'b0; bus.PC_in = '0;
    m_pc = 'x; m_err = 1'b0;
    @(negedge clk);

    step(1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b1, 32'h4);
    step(1'b1, 1'b1, 32'h8);
    step(1'b1, 1'b1, 32'hC);
    step(1'b0, 1'b1, 32'h10);
    step(1'b1, 1'b1, 32'h10);
    step(1'b1, 1'b1, 32'h14);
    step(1'b1, 1'b0, 32'h100);
    step(1'b1, 1'b0, 32'h200);
    step(1'b1, 1'b0, 32'h100);
    step(1'b1, 1'b1, 32'h200);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 32'h6);
    step(1'b1, 1'b1, 32'h8);
    step(1'b1, 1'b0, 32'h3);
    step(1'b0, 1'b0, 32'h7);
    step(1'b1, 1'b0, 32'h5);
    step(1'b1, 1'b1, 32'h20);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       p = $urandom;
        1:       p = $urandom & 32'hFFFF_FFFC;
        2:       p = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: p = 32'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0), p);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: run did not complete, expected completion before %0t", $time);
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- RISC-V program counter register. Holds the address of the instruction currently being fetched.
- Loads the next-PC value computed by the fetch/branch logic on every enabled clock edge.
- Feeds instruction memory and the PC+4 adder path.
- Single clock domain. Synchronous, active-low reset.

Parameters:
- XLEN, 32, width of PC_in/PC_out in bits (legal: 32 or 64).
- RESET_VECTOR, 32'h0000_0000, value PC_out takes on reset (zero-extended to XLEN).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous active-low reset; reset=0 at a rising clk edge forces the PC to RESET_VECTOR.
- en  input  1  load enable; 1 = load PC_in, 0 = hold (pipeline stall).
- PC_in  input  XLEN  next-PC value to load.
- PC_out  output  XLEN  current PC, registered.
- PC_plus4  output  XLEN  PC_out + 4, combinational, modulo 2^XLEN.
- misalign_err  output  1  sticky misaligned-load flag (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (port reset, low = reset asserted). No asynchronous path: changing reset between edges has no effect until the next rising clk edge.
- Reset values:
  - PC_out = RESET_VECTOR.
  - PC_plus4 = RESET_VECTOR + 4.
  - misalign_err = 0.
- Priority at each rising edge:
  1. reset==0 -> PC_out <= RESET_VECTOR, misalign_err <= 0 (overrides en and PC_in).
  2. else en==1 -> PC_out <= PC_in.
  3. else -> PC_out holds.
- Latency: one cycle. PC_in sampled at edge N appears on PC_out immediately after edge N.
- PC_in changes between edges do not affect PC_out.
- PC_plus4 is purely combinational from PC_out. It wraps at 2^XLEN: all-ones-minus-3 + 4 = 0. No carry-out port.
- Reset mid-operation: the PC is discarded and restarts at RESET_VECTOR.
- After reset deasserts, the first enabled edge loads PC_in. No extra dead cycle.
- en==0 while reset==1 holds PC_out indefinitely, including across arbitrary PC_in activity.
- Before the first reset edge, PC_out is undefined (X in simulation). Verification checks outputs only after the first reset edge.
- No other state. No internal increment: next-PC selection belongs to the caller.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - On an enabled load with PC_in[1:0] != 2'b00, PC_out <= {PC_in[XLEN-1:2], 2'b00} (low bits forced to zero).
  - misalign_err is set to 1 and stays 1 until the next reset edge.
  - A load with aligned PC_in leaves misalign_err unchanged.
  - Held cycles (en==0) never set misalign_err.
- Not defined:
  - PC_out <= PC_in verbatim, including low bits.
  - misalign_err is tied to constant 0.

Test Plan:
- Reset: hold reset=0 over one edge with PC_in=32'h0000_0000 -> PC_out=0, PC_plus4=4, misalign_err=0.
- Normal loads: reset=1, en=1; PC_in = 32'h4, 32'h8, 32'hC on successive edges -> PC_out = 4, 8, C, each one cycle after its PC_in edge. PC_plus4 = 8, C, 10.
- Reset mid-run: PC_out=32'hC, drive reset=0 for one edge with PC_in=32'h10 -> PC_out=0. After release, PC_in=32'h10 then 32'h14 -> PC_out=10, then 14.
- Stall: PC_out=32'h14, en=0, PC_in toggles 32'h100/32'h200 for three edges -> PC_out stays 14. en=1 with PC_in=32'h200 -> PC_out=200 next edge.
- Wrap: load PC_in=32'hFFFF_FFFC -> PC_out=FFFF_FFFC, PC_plus4=0.
- Alignment (PC_ALIGN_CHECK_EN defined): load PC_in=32'h0000_0006 -> PC_out=4, misalign_err=1. Then load 32'h8 -> PC_out=8, misalign_err still 1. Then reset edge -> misalign_err=0.
- Alignment (macro undefined): same 32'h6 load -> PC_out=6, misalign_err=0.
